// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the keypad event front end:
//               the debounce FSM state encoding, the "no key" code and the
//               key-code width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Debounce FSM states; HELD and RELEASE both report the key as down.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Code reported when no key is pressed / FIFO is empty.
  localparam int KEY_NONE = 0;

  // Key codes are 1-based, so NUM_KEYS keys need room for NUM_KEYS+1 values.
  function automatic int code_width(input int num_keys);
    return $clog2(num_keys + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kp_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kp_event_fifo
// Description : Small first-word-fall-through event FIFO with full flag and
//               sticky overflow. A push into a full FIFO is dropped unless a
//               pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module kp_event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr_overflow,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             empty, do_push, do_pop, drop;

  // Handshake qualification, pointer/count update and sticky overflow.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;

    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign valid     = !empty;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: rtl/keypad_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_fifo
// Description : Keypad front end. Synchronises and debounces NUM_KEYS raw
//               key lines, priority-encodes the lowest pressed key to a
//               1-based code and queues one event per debounced press.
//               Optional autorepeat while a key is held is enabled by the
//               macro KEYPAD_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter  int NUM_KEYS        = 4,
  parameter  int DEBOUNCE_CYCLES = 8,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int REPEAT_CYCLES   = 64,
  localparam int CODE_W          = code_width(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                key_pop,
  input  logic                clr_overflow,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                fifo_full,
  output logic                overflow,
  output logic                key_held
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CODE_W-1:0] CODE_NONE = CODE_W'(KEY_NONE);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  kp_state_t           state_q, state_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   enc;
  logic                press_push;
  logic                rpt_push;
  logic                push_evt;

  // Two-flop synchroniser feed and lowest-index priority encoder.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    enc     = CODE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sync2_q[i]) begin
        enc = CODE_W'(i + 1);
      end
    end
  end

  // Debounce FSM: next state, candidate code, stability counter, press push.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    press_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc != CODE_NONE) begin
          cand_d  = enc;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (enc != cand_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          press_push = 1'b1;
          state_d    = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        // Switching to another key while held does not start a new press.
        if (enc == CODE_NONE) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (enc != CODE_NONE) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Synchroniser and FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= ST_IDLE;
      cand_q  <= CODE_NONE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // Repeat timer runs only while the key stays held; first repeat comes
  // REPEAT_CYCLES cycles after the initial push.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_push  = 1'b0;
    if (state_q == ST_HELD && enc != CODE_NONE) begin
      if (rpt_cnt_q == RPT_LAST) begin
        rpt_push  = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  logic unused_repeat_cfg;

  assign rpt_push          = 1'b0;
  assign unused_repeat_cfg = (REPEAT_CYCLES != 0);
`endif

  assign push_evt = press_push | rpt_push;
  assign key_held = (state_q == ST_HELD) || (state_q == ST_RELEASE);

  kp_event_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push_evt),
    .push_data    (cand_q),
    .pop          (key_pop),
    .clr_overflow (clr_overflow),
    .head_data    (key_code),
    .valid        (key_valid),
    .full         (fifo_full),
    .overflow     (overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_event_fifo
// Description : Self-checking bench for keypad_event_fifo. Expected key codes
//               are queued when a press is driven and compared as the
//               consumer pops events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_event_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic       key_pop;
  logic       clr_overflow;
  logic [2:0] key_code;
  logic       key_valid;
  logic       fifo_full;
  logic       overflow;
  logic       key_held;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] sb[$];

  keypad_event_fifo #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (8),
    .FIFO_DEPTH      (4),
    .REPEAT_CYCLES   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_raw      (key_raw),
    .key_pop      (key_pop),
    .clr_overflow (clr_overflow),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .key_held     (key_held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    key_pop = 1'b1;
    tick();
    key_pop = 1'b0;
  endtask

  task automatic press_release(input logic [3:0] v, input int hold);
    key_raw = v;
    repeat (hold) tick();
    key_raw = 4'b0000;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_raw = '0; key_pop = 1'b0; clr_overflow = 1'b0;
    repeat (3) tick();
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", key_valid); end
    n_cmp++; if (key_code !== 3'd0) begin n_err++; $display("FAIL reset_code: got %0d, expected 0", key_code); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b, expected 0", fifo_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b, expected 0", key_held); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    int guard; logic [2:0] exp_code;
    key_raw = 4'b0100; sb.push_back(3'd3);
    repeat (10) tick();
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL sp_latency_early: valid %b after 10 edges, expected 0", key_valid); end
    tick();
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL sp_latency: valid %b after 11 edges, expected 1", key_valid); end
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL sp_held: got %b, expected 1", key_held); end
    repeat (9) tick();
    key_raw = 4'b0000;
    repeat (10) tick();
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL sp_held_release: got %b after 10 release edges, expected 1", key_held); end
    tick();
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL sp_released: got %b after 11 release edges, expected 0", key_held); end
    repeat (3) tick();
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL sp_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL sp_code: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sp_missing: %0d events not produced, expected 0", sb.size()); end
  endtask

  task automatic test_bounce();
    int guard; logic [2:0] exp_code; logic seen;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      key_raw = (((c / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (key_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL bounce_event: valid seen %b while bouncing, expected 0", seen); end
    key_raw = 4'b0001; sb.push_back(3'd1);
    repeat (12) tick();
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL bounce_stable: valid %b, expected 1", key_valid); end
    key_raw = 4'b0000;
    repeat (14) tick();
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL bounce_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL bounce_code: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bounce_missing: %0d events not produced, expected 0", sb.size()); end
  endtask

  task automatic test_simultaneous();
    int guard; logic [2:0] exp_code;
    key_raw = 4'b1010; sb.push_back(3'd2);
    repeat (12) tick();
    key_raw = 4'b1000;
    repeat (5) tick();
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL simul_held: got %b, expected 1", key_held); end
    key_raw = 4'b0000;
    repeat (14) tick();
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL simul_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL simul_code: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL simul_missing: %0d events not produced, expected 0", sb.size()); end
  endtask

  task automatic test_overflow();
    int guard; logic [2:0] exp_code; logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 4'b0001 << k;
      sb.push_back(3'(k + 1));
      press_release(v, 12);
    end
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b, expected 1", fifo_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b, expected 0", overflow); end
    press_release(4'b0001, 12);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, expected 1", overflow); end
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL ovf_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL ovf_code: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL ovf_missing: %0d events not produced, expected 0", sb.size()); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    int guard; logic [2:0] exp_code; logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 4'b0001 << k;
      sb.push_back(3'(k + 1));
      press_release(v, 12);
    end
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fp_full: got %b, expected 1", fifo_full); end
    key_raw = 4'b0010; sb.push_back(3'd2);
    repeat (10) tick();
    exp_code = sb.pop_front();
    n_cmp++; if (key_code !== exp_code) begin n_err++; $display("FAIL fp_head: got %0d, expected %0d", key_code, exp_code); end
    pop();
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fp_count: full %b, expected 1", fifo_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fp_overflow: got %b, expected 0", overflow); end
    key_raw = 4'b0000;
    repeat (14) tick();
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL fp_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL fp_code: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL fp_missing: %0d events not produced, expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int guard; logic [2:0] exp_code;
    press_release(4'b0100, 12);
    key_raw = 4'b0001;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    sb.delete();
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b, expected 0", key_valid); end
    n_cmp++; if (key_code !== 3'd0) begin n_err++; $display("FAIL rm_code: got %0d, expected 0", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL rm_held: got %b, expected 0", key_held); end
    rst = 1'b0; sb.push_back(3'd1);
    repeat (10) tick();
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rm_latency_early: valid %b, expected 0", key_valid); end
    tick();
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL rm_latency: valid %b, expected 1", key_valid); end
    key_raw = 4'b0000;
    repeat (14) tick();
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL rm_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL rm_code_pop: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rm_missing: %0d events not produced, expected 0", sb.size()); end
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int guard; logic [2:0] exp_code;
    key_raw = 4'b1000;
    repeat (3) sb.push_back(3'd4);
    repeat (51) tick();
    key_raw = 4'b0000;
    repeat (14) tick();
    guard = 0;
    while (key_valid === 1'b1 && guard < 8) begin
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL rpt_extra: got code %0d, expected no event", key_code); end
      else begin exp_code = sb.pop_front(); if (key_code !== exp_code) begin n_err++; $display("FAIL rpt_code: got %0d, expected %0d", key_code, exp_code); end end
      pop(); guard++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rpt_missing: %0d events not produced, expected 0", sb.size()); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_reset_mid();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_event_fifo.md
Name: keypad_event_fifo

Overview:
- Parametrised keypad front end: synchronises and debounces NUM_KEYS raw key lines and priority-encodes the pressed key to a 1-based code (0 = no key).
- Pushes one event per debounced press into a small FIFO, which the consumer drains with a pop handshake.
- Replaces the fixed 4-key load/clear capture register: adds debouncing, buffering, overflow reporting and a held-key indication.
- Sits between the keypad pins and the access-control FSM.

Parameters:
- NUM_KEYS, 4, number of key inputs (1..15).
- DEBOUNCE_CYCLES, 8, clock cycles a code must stay stable to count as pressed or released (>=2).
- FIFO_DEPTH, 4, event FIFO entries; power of 2, >=2.
- REPEAT_CYCLES, 64, autorepeat period; used only when KEYPAD_AUTOREPEAT_EN is defined.
- Derived constant CODE_W = $clog2(NUM_KEYS+1).

Ports:
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- key_raw, in, NUM_KEYS, asynchronous key levels; 1 = pressed.
- key_pop, in, 1, consumer takes the head event; honoured only when key_valid=1.
- clr_overflow, in, 1, clears sticky overflow.
- key_code, out, CODE_W, FIFO head code (key index+1); 0 when empty.
- key_valid, out, 1, FIFO non-empty.
- fifo_full, out, 1, FIFO holds FIFO_DEPTH entries.
- overflow, out, 1, sticky: an event was dropped because the FIFO was full.
- key_held, out, 1, debounced key currently down (HELD or RELEASE state).

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, synchronisers=0, FSM=IDLE, counters=0. Outputs: key_code=0, key_valid=0, fifo_full=0, overflow=0, key_held=0. A reset mid-debounce or mid-hold discards the press; a key still held after reset is re-debounced and produces a new event.
- Input path:
  - Two-flop synchroniser per line, giving sync vector s.
  - enc = lowest-index set bit of s, plus 1; enc = 0 if none set.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. Registers: cand (CODE_W bits) and cnt.
  - IDLE: if enc!=0 then cand<=enc, cnt<=0, go to DEBOUNCE.
  - DEBOUNCE:
    - enc!=cand: return to IDLE (re-arms on the next cycle).
    - otherwise, when cnt==DEBOUNCE_CYCLES-1: push cand, go to HELD.
    - otherwise cnt++.
  - HELD: if enc==0 then cnt<=0, go to RELEASE. A change to a different non-zero code is ignored; one event per press.
  - RELEASE:
    - enc!=0: return to HELD.
    - when cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - otherwise cnt++.
- Latency: key_valid rises DEBOUNCE_CYCLES+3 rising edges after key_raw is first sampled high, counting that edge as 1, provided the FIFO was empty.
- FIFO (registered, first-word fall-through):
  - key_code shows the head combinationally from storage.
  - Pop when key_pop=1 and key_valid=1. key_pop while empty is ignored.
  - Push while full and no pop in the same cycle: event dropped, overflow<=1.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: cleared by clr_overflow. If a drop and clr_overflow occur in the same cycle, the drop wins (overflow=1).
- key_held=1 in HELD and RELEASE.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined: while in HELD, a repeat counter re-pushes cand every REPEAT_CYCLES cycles, first repeat REPEAT_CYCLES cycles after the initial push. The counter resets on leaving HELD. Repeats obey the same overflow rules.
- Undefined: exactly one event per press; REPEAT_CYCLES has no effect; no repeat logic is synthesised.

Decomposition:
- Shared package keypad_pkg:
  - FSM state enum kp_state_t.
  - Function clog2-based code_width().
  - Constant KEY_NONE = 0.
- One natural sub-module: kp_event_fifo, the parametrised FIFO (width CODE_W, depth FIFO_DEPTH) with full/empty/overflow. The debounce FSM and encoder stay in the top module.

Test Plan (NUM_KEYS=4, DEBOUNCE_CYCLES=8, FIFO_DEPTH=4):
- Press key_raw=4'b0100 for 20 cycles, then release -> key_valid rises 11 edges after the press, key_code=3, exactly one event, key_held high until 8 stable-release cycles.
- Bounce: key_raw=0001 toggling every 3 cycles for 30 cycles, then stable for 12 -> no event during bouncing, one event code=1 after stabilising.
- Simultaneous press 4'b1010 -> code=2. Then drop bit1 while holding bit3 -> no new event.
- Five distinct presses with no pops -> fifo_full=1 after 4, overflow=1 on the 5th, codes popped in order. Then clr_overflow -> overflow=0.
- FIFO full, debounced push coincides with key_pop -> count stays 4, overflow stays 0, new code at the tail.
- rst asserted at debounce cycle 5 while the key is still held -> all outputs 0. After rst drops, the event appears DEBOUNCE_CYCLES+3 edges later. With KEYPAD_AUTOREPEAT_EN and REPEAT_CYCLES=16, holding the key for 40 cycles after the first push -> 3 events total.
